// File: rtl/second_chance_slot_writer_pkg.sv
// Shared definitions for the second-chance slot writer: FSM states and
// the flattened (line, slot) ordering that matches the bucket read mux.
package second_chance_slot_writer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int flat_idx(input int line, input int slot, input int bucket_size);
        return line * bucket_size + slot;
    endfunction

endpackage

// File: rtl/second_chance_slot_writer_lowest_set_onehot.sv
// Lowest-set-bit finder: one-hot of the lowest set bit, its index and an
// any-set flag.
module lowest_set_onehot
    import second_chance_slot_writer_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int IW = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    assign onehot_o = vec_i & (~vec_i + WIDTH'(1));
    assign any_o    = |vec_i;

    // Walk downward so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/second_chance_slot_writer.sv
// Chooses the write slot for one insert: lowest free slot, else a victim
// picked by a second-chance clock hand; emits a one-hot write pulse.
module second_chance_slot_writer
    import second_chance_slot_writer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BUCKET_SIZE = 1,
    parameter int DATA_LINES  = 4,
    localparam int N     = DATA_LINES * BUCKET_SIZE,
    localparam int IDX_W = idx_width(N)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    input  logic [DATA_LINES-1:0][BUCKET_SIZE-1:0] slot_valid,
    input  logic [DATA_LINES-1:0][BUCKET_SIZE-1:0] slot_ref,
    output logic [DATA_WIDTH-1:0]                  wr_data,
    output logic [DATA_LINES-1:0][BUCKET_SIZE-1:0] wr_en,
    output logic [DATA_LINES-1:0][BUCKET_SIZE-1:0] clr_ref,
    output logic                                   evict,
    output logic [IDX_W-1:0]                       victim_idx,
    output logic [1:0]                             dbg_state,
    output logic [IDX_W-1:0]                       dbg_hand
);

    // Handshake: an insert is taken on a clock edge where in_valid && in_ready;
    // in_ready is high only in IDLE, and the source holds its request until then.

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      hand_q, hand_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [N-1:0]          valid_snap_q, valid_snap_d;
    logic [N-1:0]          ref_snap_q, ref_snap_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [N-1:0]          wr_en_q, wr_en_d;
    logic [N-1:0]          clr_ref_q, clr_ref_d;
    logic                  evict_q, evict_d;
    logic [IDX_W-1:0]      victim_idx_q, victim_idx_d;

    logic [N-1:0]          valid_flat, ref_flat;
    logic [N-1:0]          free_onehot;
    logic [IDX_W-1:0]      free_idx;
    logic                  free_any;
    logic [IDX_W-1:0]      hand_inc;
    logic [N-1:0]          target_oh;
    logic [IDX_W-1:0]      target_idx;
    logic                  evict_dec;

    always_comb begin
        valid_flat = '0;
        ref_flat   = '0;
        for (int i = 0; i < DATA_LINES; i++) begin
            for (int j = 0; j < BUCKET_SIZE; j++) begin
                valid_flat[flat_idx(i, j, BUCKET_SIZE)] = slot_valid[i][j];
                ref_flat[flat_idx(i, j, BUCKET_SIZE)]   = slot_ref[i][j];
            end
        end
    end

    lowest_set_onehot #(.WIDTH(N)) u_free (
        .vec_i    (~valid_snap_q),
        .onehot_o (free_onehot),
        .idx_o    (free_idx),
        .any_o    (free_any)
    );

    assign hand_inc = (hand_q == IDX_W'(N - 1)) ? '0 : hand_q + IDX_W'(1);

    always_comb begin
        state_d      = state_q;
        hand_d       = hand_q;
        data_d       = data_q;
        valid_snap_d = valid_snap_q;
        ref_snap_d   = ref_snap_q;
        wr_data_d    = wr_data_q;
        victim_idx_d = victim_idx_q;
        wr_en_d      = '0;
        clr_ref_d    = '0;
        evict_d      = 1'b0;
        target_oh    = '0;
        target_idx   = '0;
        evict_dec    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d       = in_data;
                    valid_snap_d = valid_flat;
                    ref_snap_d   = ref_flat;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                if (free_any) begin
                    target_oh  = free_onehot;
                    target_idx = free_idx;
                    state_d    = WRITE;
                end else if (ref_snap_q[hand_q]) begin
                    ref_snap_d[hand_q] = 1'b0;
                    hand_d             = hand_inc;
                end else begin
                    target_oh  = N'(1) << hand_q;
                    target_idx = hand_q;
                    evict_dec  = 1'b1;
                    hand_d     = hand_inc;
                    state_d    = WRITE;
                end
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == WRITE) begin
            wr_en_d      = target_oh;
            wr_data_d    = data_q;
            victim_idx_d = target_idx;
            evict_d      = evict_dec;
        end
        // Look ahead one edge so the registered clr_ref lines up with the SCAN cycle that skips.
        if (state_d == SCAN && (&valid_snap_d) && ref_snap_d[hand_d]) begin
            clr_ref_d = N'(1) << hand_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hand_q       <= '0;
            data_q       <= '0;
            valid_snap_q <= '0;
            ref_snap_q   <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= '0;
            clr_ref_q    <= '0;
            evict_q      <= 1'b0;
            victim_idx_q <= '0;
        end else begin
            state_q      <= state_d;
            hand_q       <= hand_d;
            data_q       <= data_d;
            valid_snap_q <= valid_snap_d;
            ref_snap_q   <= ref_snap_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            clr_ref_q    <= clr_ref_d;
            evict_q      <= evict_d;
            victim_idx_q <= victim_idx_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign clr_ref    = clr_ref_q;
    assign evict      = evict_q;
    assign victim_idx = victim_idx_q;
    assign dbg_state  = state_q;
    assign dbg_hand   = hand_q;

endmodule

// File: doc/second_chance_slot_writer.md
Name: second_chance_slot_writer

Overview:
Write-side counterpart of the one-hot AND-OR bucket read mux in the second-chance hashtable. It accepts one insert word and chooses the target slot among DATA_LINES x BUCKET_SIZE candidates. It takes the lowest-index free slot; if none is free, it runs a second-chance clock hand to pick a victim. It then broadcasts the data with a one-hot write enable, using the same flattened slot order as the read mux.

Parameters:
DATA_WIDTH, 32, width of one stored entry
BUCKET_SIZE, 1, slots per table line
DATA_LINES, 4, number of candidate lines (tables)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  insert request valid
in_ready  output  1  block can accept an insert
in_data  input  DATA_WIDTH  entry to insert
slot_valid  input  [DATA_LINES-1:0][BUCKET_SIZE-1:0]  occupancy of candidate slots, sampled on accept
slot_ref  input  [DATA_LINES-1:0][BUCKET_SIZE-1:0]  second-chance reference bits, sampled on accept
wr_data  output  DATA_WIDTH  registered write data, broadcast to all slots
wr_en  output  [DATA_LINES-1:0][BUCKET_SIZE-1:0]  one-hot write enable, 1-cycle pulse
clr_ref  output  [DATA_LINES-1:0][BUCKET_SIZE-1:0]  one-hot pulse clearing the ref bit of the slot the hand skips
evict  output  1  high with wr_en when an occupied slot is overwritten
victim_idx  output  IDX_W  flattened index of the written slot, valid with wr_en

Behaviour:
- Defined constants: N = DATA_LINES*BUCKET_SIZE; IDX_W = max(1, $clog2(N)). Flat index of (line i, slot j) = i*BUCKET_SIZE+j, identical to the read mux ordering.
- States:
  - IDLE: in_ready=1.
  - SCAN: in_ready=0; evaluates slot occupancy and runs the clock hand.
  - WRITE: in_ready=0; drives the write pulse.
- Reset values: state IDLE, hand=0, wr_en=0, clr_ref=0, evict=0, victim_idx=0, wr_data=0, in_ready=1.
- Accept: in_valid & in_ready at an edge latches in_data, slot_valid and slot_ref into local snapshots; next state SCAN.
- SCAN, any snapshot valid bit = 0: target = lowest free flat index; next state WRITE; evict=0; hand unchanged.
- SCAN, all slots occupied, snapshot ref[hand]=1:
  - clear local ref[hand];
  - clr_ref one-hot at hand for that cycle;
  - hand = (hand+1) mod N;
  - stay in SCAN.
- SCAN, all slots occupied, snapshot ref[hand]=0: target = hand; evict=1; hand = (hand+1) mod N; next state WRITE.
- WRITE: for exactly one cycle, wr_en is one-hot at target, wr_data = latched data, victim_idx = target, evict as decided; next state IDLE.
- All outputs other than in_ready are registered. wr_en, clr_ref and evict are 0 outside their pulse cycles.
- Latency from the accept edge: wr_en high in cycle +2, plus one cycle per skipped ref=1 slot. Worst case N+2; termination is guaranteed because the hand clears every ref bit within one pass.
- Back-to-back: a new accept is possible in the cycle after WRITE (IDLE). The minimum issue interval is 3 cycles.
- Hand wrap: N-1 -> 0. When N=1, hand is constant 0.
- Snapshots are taken only on accept; slot_valid and slot_ref changes during SCAN are ignored.
- Reset mid-operation (SCAN or WRITE): return to IDLE, hand=0, no wr_en pulse emitted, pending insert dropped.
- in_valid while busy: not accepted, no side effects; the request is held by the source.

Decomposition:
- Shared package: function flat_idx(line, slot, BUCKET_SIZE); IDX_W computation; state enum typedef {IDLE, SCAN, WRITE}.
- One sub-module: lowest_set_onehot (parameter WIDTH). Input vector; outputs one-hot of the lowest set bit, its index, and an any flag. Used on the inverted valid snapshot.

Test Plan:
Configuration DATA_LINES=4, BUCKET_SIZE=1 unless noted.
1. Reset held 2 cycles -> in_ready=1, wr_en=0, clr_ref=0, evict=0, hand=0.
2. slot_valid=4'b1011, in_data=32'hDEADBEEF accepted at cycle 0 -> cycle 2: wr_en=4'b0100, wr_data=32'hDEADBEEF, victim_idx=2, evict=0; hand stays 0.
3. Full (4'b1111), slot_ref=4'b0000, hand=0 -> cycle 2: wr_en=4'b0001, evict=1, victim_idx=0; hand becomes 1.
4. Full, slot_ref=4'b1111, hand=1 ->
   - clr_ref=0010, 0100, 1000, 0001 in cycles 1..4;
   - cycle 6: wr_en=4'b0010, evict=1;
   - hand=2 afterwards (worst case N+2).
5. in_valid held high across two inserts -> exactly one accept per IDLE cycle, in_ready=0 during SCAN/WRITE, second wr_en no earlier than cycle 5.
6. Reset asserted in the 2nd SCAN cycle of scenario 4 -> no wr_en pulse, hand=0, in_ready=1 in the following cycle; a repeat of scenario 2 afterwards with BUCKET_SIZE=2, DATA_LINES=2 and valid={2'b11,2'b01} -> wr_en[0][1] set (flat index 1).
